// File: rtl/inst_prefetch_queue_if.sv
// Bundle of the instruction-memory, redirect and dequeue signals of the
// prefetch queue. The master modport is the queue itself; the slave
// modport is its environment (memory, execute and decode stages).
interface inst_prefetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_addr;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_addr,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_addr,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, deq_ready
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues word fetches ahead of decode, keeps
// returned instructions in a small FIFO and flushes on control-flow redirect.
// Requests are credit limited so that every outstanding response always has
// a free queue slot waiting for it.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [31:0]      NOP_INST  = 32'h0000_0013;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [31:0]        addr_mem_q [DEPTH];
    logic [31:0]        inst_mem_q [DEPTH];

    logic               req;
    logic               gnt_fire;
    logic               rsp_fire;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   wr_idx;
    logic [31:0]        redirect_pc_aligned;

    // Handshake decode: request credit, grant, response retire, push and pop strobes
    always_comb begin
        req      = !rst && (state_q == RUN) && !bus.redirect &&
                   (outstanding_q < MAX_OUT_C) &&
                   ((int'(count_q) + int'(outstanding_q)) < DEPTH);
        gnt_fire = req && bus.imem_gnt;
        // A response with nothing outstanding is illegal and simply dropped
        rsp_fire = !rst && bus.imem_rvalid && (outstanding_q != '0);
        push     = rsp_fire && (state_q == RUN) && !bus.redirect;
        pop      = (count_q != '0) && bus.deq_ready && !bus.redirect;
        wr_idx   = head_q + count_q[PTR_W-1:0];
        redirect_pc_aligned = {bus.redirect_pc[31:2], 2'b00};
    end

    // Datapath next state: PCs, occupancy, credit counter, head pointer
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        head_d        = head_q;

        if (gnt_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!gnt_fire && rsp_fire) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        // Redirect wins over everything: drop the queue and restart both PCs
        if (bus.redirect) begin
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            count_d    = '0;
        end
    end

    // FSM next state: flush stale responses after a redirect until none remain
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = (outstanding_d != '0) ? FLUSH : RUN;
        end else if ((state_q == FLUSH) && (outstanding_d == '0)) begin
            state_d = RUN;
        end
    end

    // Outputs: memory request and registered queue head
    always_comb begin
        bus.imem_req  = req;
        bus.imem_addr = {fetch_pc_q[31:2], 2'b00};
        bus.out_valid = !rst && (count_q != '0);
        bus.out_inst  = NOP_INST;
        bus.out_addr  = 32'h0000_0000;
        if (bus.out_valid) begin
            bus.out_inst = inst_mem_q[head_q];
            bus.out_addr = addr_mem_q[head_q];
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            head_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            head_q        <= head_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_idx] <= resp_pc_q;
            inst_mem_q[wr_idx] <= bus.imem_rdata;
        end
    end

    // Protocol checks: no response without a request, no push into a full queue
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.imem_rvalid && (outstanding_q == '0)));
            assert (!(push && (count_q == DEPTH_C)));
        end
    end
endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-002 Parameter MAX_OUT, default 2, maximum outstanding instruction-memory requests (1..DEPTH).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  fetch address; word aligned, bits[1:0] always 0.
REQ-008 imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req=1).
REQ-009 imem_rvalid  in  1  response data valid; responses return in request order.
REQ-010 imem_rdata  in  32  instruction word for oldest outstanding request.
REQ-011 redirect  in  1  control-flow redirect (taken branch/jump) from execute stage.
REQ-012 redirect_pc  in  32  target address; bits[1:0] ignored.
REQ-013 deq_ready  in  1  fetch/decode pipeline register accepts an instruction (not stalled).
REQ-014 out_valid  out  1  queue head holds a valid instruction.
REQ-015 out_inst  out  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0.
REQ-016 out_addr  out  32  address of head instruction; 0 when out_valid=0.

Function
REQ-017 State: fetch_pc, resp_pc, count (0..DEPTH), outstanding (0..MAX_OUT), FSM {RUN, FLUSH}.
REQ-018 RUN: imem_req=1 iff redirect=0 and outstanding<MAX_OUT and count+outstanding<DEPTH; imem_addr=fetch_pc.
REQ-019 FLUSH: imem_req=0; every imem_rvalid is discarded and decrements outstanding.
REQ-020 Grant: imem_req & imem_gnt -> fetch_pc+=4 (mod 2^32, wraps FFFF_FFFC->0), outstanding+=1.
REQ-021 Once imem_req=1 without gnt, imem_req and imem_addr hold stable next cycle unless redirect=1.
REQ-022 RUN response: imem_rvalid -> push {resp_pc, imem_rdata}, resp_pc+=4, outstanding-=1; head visible next cycle (1-cycle rvalid-to-out_valid latency, no bypass).
REQ-023 Grant and rvalid same cycle: outstanding unchanged.
REQ-024 Dequeue: out_valid & deq_ready -> pop head; push and pop same cycle leave count unchanged; order preserved.
REQ-025 Credit rule guarantees no push when full; push with count=DEPTH is an assertion failure.
REQ-026 Redirect (highest priority, any state): queue emptied (count=0), fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}, no request issued, any pop ignored.
REQ-027 Redirect next state: FLUSH if outstanding after this cycle (counting a same-cycle rvalid as retired and discarded) >0, else RUN.
REQ-028 FLUSH -> RUN the cycle outstanding reaches 0; redirect during FLUSH updates PCs, stays FLUSH.
REQ-029 out_valid = (count!=0); outputs driven from registered queue head only.
REQ-030 imem_rvalid with outstanding=0 is an assertion failure; data ignored.

Reset
REQ-031 rst=1: fetch_pc=resp_pc=RESET_PC, count=0, outstanding=0, FSM=RUN, queue cleared.
REQ-032 During rst=1 cycle: imem_req=0, out_valid=0, out_inst=32'h13, out_addr=0; first request in first cycle with rst=0.
REQ-033 rst mid-operation discards all queued entries and outstanding responses; rvalid after reset with outstanding=0 flagged per REQ-030 (bench keeps memory quiet).

Verification
REQ-034 Reset then gnt=1, 1-cycle rvalid, deq_ready=1 -> out_addr sequence 0,4,8,... one per cycle after ramp-up; imem_addr 0 in first post-reset cycle.
REQ-035 deq_ready=0 throughout -> exactly 4 entries fill, imem_req drops to 0 once count+outstanding=4, out_addr stays 0.
REQ-036 Two requests outstanding, redirect to 0x0000_0103 -> queue empty, FLUSH, two later responses discarded, next imem_addr 0x0000_0100, first out_addr 0x100.
REQ-037 gnt held 0 for 3 cycles -> imem_req=1, imem_addr constant; gnt=1 -> fetch_pc advances by 4.
REQ-038 redirect_pc 0xFFFF_FFFC, consume -> out_addr 0xFFFF_FFFC then 0x0000_0000.
REQ-039 Redirect coinciding with rvalid and deq_ready when count=1, outstanding=1 -> response dropped, count=0, FSM=RUN next cycle.
